// File: rtl/id_decode_unit_pkg.sv
// rv32i_types: shared RV32I decode types, shared by the decode unit and its bench
package rv32i_types;

    localparam int XLEN = 32;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } rv32i_opcode;

    typedef enum logic [2:0] {
        beq  = 3'b000,
        bne  = 3'b001,
        blt  = 3'b100,
        bge  = 3'b101,
        bltu = 3'b110,
        bgeu = 3'b111
    } branch_funct3_t;

    typedef enum logic [2:0] {
        lb  = 3'b000,
        lh  = 3'b001,
        lw  = 3'b010,
        lbu = 3'b100,
        lhu = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        sb = 3'b000,
        sh = 3'b001,
        sw = 3'b010
    } store_funct3_t;

    typedef enum logic [2:0] {
        f3_add  = 3'b000,
        f3_sll  = 3'b001,
        f3_slt  = 3'b010,
        f3_sltu = 3'b011,
        f3_xor  = 3'b100,
        f3_sr   = 3'b101,
        f3_or   = 3'b110,
        f3_and  = 3'b111
    } arith_funct3_t;

    typedef enum logic [2:0] {
        alu_add = 3'b000,
        alu_sll = 3'b001,
        alu_sra = 3'b010,
        alu_sub = 3'b011,
        alu_xor = 3'b100,
        alu_srl = 3'b101,
        alu_or  = 3'b110,
        alu_and = 3'b111
    } alu_ops;

    typedef enum logic {
        cmpmux_rs2   = 1'b0,
        cmpmux_i_imm = 1'b1
    } cmpmux_sel_t;

    typedef enum logic {
        controlmux_norm = 1'b0,
        controlmux_zero = 1'b1
    } controlmux_sel_t;

    typedef enum logic {
        alumux1_rs1 = 1'b0,
        alumux1_pc  = 1'b1
    } alumux1_sel_t;

    typedef enum logic [2:0] {
        alumux2_i_imm = 3'd0,
        alumux2_u_imm = 3'd1,
        alumux2_b_imm = 3'd2,
        alumux2_s_imm = 3'd3,
        alumux2_j_imm = 3'd4,
        alumux2_rs2   = 3'd5
    } alumux2_sel_t;

    typedef enum logic [3:0] {
        rfmux_alu_out  = 4'd0,
        rfmux_br_en    = 4'd1,
        rfmux_u_imm    = 4'd2,
        rfmux_lw       = 4'd3,
        rfmux_pc_plus4 = 4'd4,
        rfmux_lb       = 4'd5,
        rfmux_lbu      = 4'd6,
        rfmux_lh       = 4'd7,
        rfmux_lhu      = 4'd8
    } regfilemux_sel_t;

    typedef struct packed {
        rv32i_opcode     opcode;
        logic [2:0]      funct3;
        alu_ops          aluop;
        alumux1_sel_t    alumux1_sel;
        alumux2_sel_t    alumux2_sel;
        regfilemux_sel_t regfilemux_sel;
        branch_funct3_t  cmpop;
        cmpmux_sel_t     cmpmux_sel;
        logic            load_regfile;
        logic            mem_read;
        logic            mem_write;
        logic [3:0]      mem_byte_en;
    } rv32i_control_word;

    function automatic regfilemux_sel_t load_mux(input logic [2:0] funct3);
        return funct3 == lb  ? rfmux_lb  :
               funct3 == lh  ? rfmux_lh  :
               funct3 == lbu ? rfmux_lbu :
               funct3 == lhu ? rfmux_lhu : rfmux_lw;
    endfunction

endpackage

// File: rtl/id_decode_unit_regfile.sv
// id_regfile: 32x32 register file, x0 hardwired to zero, optional write-through
// Ports: clk, rst (sync, active-high, beats writes); we_i/rd_i/wd_i write port;
//        rs1_i/rs2_i read indices, rs1_data_o/rs2_data_o combinational read data.
// Config: `define REGFILE_BYPASS_EN makes a same-cycle write visible on the read ports.
module id_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  rd_i,
    input  logic [31:0] wd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    output logic [31:0] rs1_data_o,
    output logic [31:0] rs2_data_o
);
    logic [31:0][31:0] regs_q, regs_d;
    logic byp1, byp2;

    always_comb begin
        regs_d = regs_q;
        if (we_i && rd_i != 5'd0) regs_d[rd_i] = wd_i;
    end

    always_ff @(posedge clk) begin
        if (rst) regs_q <= '0;
        else     regs_q <= regs_d;
    end

`ifdef REGFILE_BYPASS_EN
    assign byp1 = we_i && rd_i != 5'd0 && rd_i == rs1_i;
    assign byp2 = we_i && rd_i != 5'd0 && rd_i == rs2_i;
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    // Reads are forced to zero while reset is asserted, before the array clears.
    assign rs1_data_o = rst || rs1_i == 5'd0 ? 32'd0 : byp1 ? wd_i : regs_q[rs1_i];
    assign rs2_data_o = rst || rs2_i == 5'd0 ? 32'd0 : byp2 ? wd_i : regs_q[rs2_i];

endmodule

// File: rtl/id_decode_unit.sv
// id_decode_unit: RV32I ID stage - register file, control ROM, branch comparator, bubble squash
// Ports: clk, rst (sync, active-high); load_regfile_i/rd_wr_i/wr_data_i WB write port;
//        instr_i/pc_i from IF/ID; controlmux_sel_i bubble select; ctrl_word_o squashed control;
//        instr_o/pc_o pass-through; rs1/rs2 data; i/s/b/u/j immediates; rs1/rs2/rd indices; br_en_o.
// Config: `define REGFILE_BYPASS_EN enables regfile write-through.
module id_decode_unit
    import rv32i_types::*;
#(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_regfile_i,
    input  logic [4:0]        rd_wr_i,
    input  logic [WIDTH-1:0]  wr_data_i,
    input  logic [WIDTH-1:0]  instr_i,
    input  logic [WIDTH-1:0]  pc_i,
    input  controlmux_sel_t   controlmux_sel_i,
    output rv32i_control_word ctrl_word_o,
    output logic [WIDTH-1:0]  instr_o,
    output logic [WIDTH-1:0]  pc_o,
    output logic [WIDTH-1:0]  rs1_data_o,
    output logic [WIDTH-1:0]  rs2_data_o,
    output logic [WIDTH-1:0]  i_imm_o,
    output logic [WIDTH-1:0]  s_imm_o,
    output logic [WIDTH-1:0]  b_imm_o,
    output logic [WIDTH-1:0]  u_imm_o,
    output logic [WIDTH-1:0]  j_imm_o,
    output logic [4:0]        rs1_o,
    output logic [4:0]        rs2_o,
    output logic [4:0]        rd_o,
    output logic              br_en_o
);
    rv32i_control_word cw;
    logic [6:0]        opc;
    logic [2:0]        funct3;
    logic              funct7_5;
    logic              known;
    logic [31:0]       cmp_b;

    assign opc      = instr_i[6:0];
    assign funct3   = instr_i[14:12];
    assign funct7_5 = instr_i[30];
    assign instr_o  = instr_i;
    assign pc_o     = pc_i;
    assign rs1_o    = instr_i[19:15];
    assign rs2_o    = instr_i[24:20];
    assign rd_o     = instr_i[11:7];

    assign i_imm_o = {{21{instr_i[31]}}, instr_i[30:20]};
    assign s_imm_o = {{21{instr_i[31]}}, instr_i[30:25], instr_i[11:7]};
    assign b_imm_o = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign u_imm_o = {instr_i[31:12], 12'h000};
    assign j_imm_o = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

    id_regfile u_regfile (
        .clk        (clk),
        .rst        (rst),
        .we_i       (load_regfile_i),
        .rd_i       (rd_wr_i),
        .wd_i       (wr_data_i),
        .rs1_i      (rs1_o),
        .rs2_i      (rs2_o),
        .rs1_data_o (rs1_data_o),
        .rs2_data_o (rs2_data_o)
    );

    always_comb begin
        cw    = '0;
        known = 1'b1;
        case (opc)
            op_lui: begin
                cw.load_regfile   = 1'b1;
                cw.regfilemux_sel = rfmux_u_imm;
            end
            op_auipc: begin
                cw.load_regfile = 1'b1;
                cw.aluop        = alu_add;
                cw.alumux1_sel  = alumux1_pc;
                cw.alumux2_sel  = alumux2_u_imm;
            end
            op_jal, op_jalr: begin
                cw.load_regfile   = 1'b1;
                cw.regfilemux_sel = rfmux_pc_plus4;
            end
            op_br: begin
                cw.cmpop      = branch_funct3_t'(funct3);
                cw.cmpmux_sel = cmpmux_rs2;
            end
            op_load: begin
                cw.load_regfile   = 1'b1;
                cw.mem_read       = 1'b1;
                cw.mem_byte_en    = 4'b1111;
                cw.aluop          = alu_add;
                cw.alumux2_sel    = alumux2_i_imm;
                cw.regfilemux_sel = load_mux(funct3);
            end
            op_store: begin
                cw.mem_write   = 1'b1;
                cw.aluop       = alu_add;
                cw.alumux2_sel = alumux2_s_imm;
                cw.mem_byte_en = funct3 == sb ? 4'b0001 : funct3 == sh ? 4'b0011 : 4'b1111;
            end
            op_imm, op_reg: begin
                cw.load_regfile = 1'b1;
                cw.cmpmux_sel   = opc == op_imm ? cmpmux_i_imm : cmpmux_rs2;
                cw.alumux2_sel  = opc == op_imm ? alumux2_i_imm : alumux2_rs2;
                // bit 30 is only an opcode modifier for shifts (both forms) and add (register form)
                cw.aluop = !funct7_5 ? alu_ops'(funct3) :
                           funct3 == f3_sr ? alu_sra :
                           funct3 == f3_add && opc == op_reg ? alu_sub : alu_ops'(funct3);
                if (funct3 == f3_slt || funct3 == f3_sltu) begin
                    cw.cmpop          = funct3 == f3_slt ? blt : bltu;
                    cw.regfilemux_sel = rfmux_br_en;
                end
            end
            default: known = 1'b0;
        endcase
        cw.opcode = known ? rv32i_opcode'(opc) : rv32i_opcode'(7'd0);
        cw.funct3 = known ? funct3 : 3'd0;
    end

    assign cmp_b = cw.cmpmux_sel == cmpmux_i_imm ? i_imm_o : rs2_data_o;

    always_comb begin
        case (cw.cmpop)
            beq:     br_en_o = rs1_data_o == cmp_b;
            bne:     br_en_o = rs1_data_o != cmp_b;
            blt:     br_en_o = $signed(rs1_data_o) < $signed(cmp_b);
            bge:     br_en_o = $signed(rs1_data_o) >= $signed(cmp_b);
            bltu:    br_en_o = rs1_data_o < cmp_b;
            bgeu:    br_en_o = rs1_data_o >= cmp_b;
            default: br_en_o = 1'b0;
        endcase
    end

    // A bubble only kills architectural side effects; datapath selects stay intact.
    always_comb begin
        ctrl_word_o = cw;
        if (controlmux_sel_i == controlmux_zero) begin
            ctrl_word_o.load_regfile = 1'b0;
            ctrl_word_o.mem_read     = 1'b0;
            ctrl_word_o.mem_write    = 1'b0;
            ctrl_word_o.mem_byte_en  = 4'b0000;
        end
    end

endmodule

// File: tb/tb_id_decode_unit.sv
// tb_id_decode_unit: directed self-checking bench for id_decode_unit
module tb_id_decode_unit;
    import rv32i_types::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              load_regfile_i;
    logic [4:0]        rd_wr_i;
    logic [31:0]       wr_data_i;
    logic [31:0]       instr_i;
    logic [31:0]       pc_i;
    controlmux_sel_t   controlmux_sel_i;
    rv32i_control_word ctrl_word_o;
    logic [31:0]       instr_o, pc_o, rs1_data_o, rs2_data_o;
    logic [31:0]       i_imm_o, s_imm_o, b_imm_o, u_imm_o, j_imm_o;
    logic [4:0]        rs1_o, rs2_o, rd_o;
    logic              br_en_o;
    int                n_cmp = 0;
    int                n_err = 0;

    id_decode_unit dut (
        .clk              (clk),
        .rst              (rst),
        .load_regfile_i   (load_regfile_i),
        .rd_wr_i          (rd_wr_i),
        .wr_data_i        (wr_data_i),
        .instr_i          (instr_i),
        .pc_i             (pc_i),
        .controlmux_sel_i (controlmux_sel_i),
        .ctrl_word_o      (ctrl_word_o),
        .instr_o          (instr_o),
        .pc_o             (pc_o),
        .rs1_data_o       (rs1_data_o),
        .rs2_data_o       (rs2_data_o),
        .i_imm_o          (i_imm_o),
        .s_imm_o          (s_imm_o),
        .b_imm_o          (b_imm_o),
        .u_imm_o          (u_imm_o),
        .j_imm_o          (j_imm_o),
        .rs1_o            (rs1_o),
        .rs2_o            (rs2_o),
        .rd_o             (rd_o),
        .br_en_o          (br_en_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] r, input logic [31:0] d);
        load_regfile_i = 1'b1;
        rd_wr_i        = r;
        wr_data_i      = d;
        tick();
        load_regfile_i = 1'b0;
    endtask

    task automatic exec(input logic [31:0] ins, input controlmux_sel_t sel);
        instr_i          = ins;
        controlmux_sel_i = sel;
        #1;
    endtask

    initial begin
        logic [4:0] r;
        rst              = 1'b1;
        load_regfile_i   = 1'b1;
        rd_wr_i          = 5'd1;
        wr_data_i        = 32'h0000_1234;
        pc_i             = 32'h0000_0100;
        instr_i          = 32'h0010_8033;
        controlmux_sel_i = controlmux_norm;
        #1;
        check("rst_read_zero", rs1_data_o, 32'h0);
        tick();
        rst            = 1'b0;
        load_regfile_i = 1'b0;
        for (int i = 1; i < 32; i++) begin
            r = 5'(i);
            exec({7'b0, r, r, 3'b000, 5'd0, 7'b0110011}, controlmux_norm);
            check($sformatf("reset_x%0d_rs1", i), rs1_data_o, 32'h0);
            check($sformatf("reset_x%0d_rs2", i), rs2_data_o, 32'h0);
            tick();
        end

        exec(32'h0000_0033, controlmux_norm);
        load_regfile_i = 1'b1;
        rd_wr_i        = 5'd0;
        wr_data_i      = 32'd5;
        #1;
        check("x0_same_cycle", rs1_data_o, 32'h0);
        tick();
        load_regfile_i = 1'b0;
        #1;
        check("x0_after_write", rs1_data_o, 32'h0);

        exec(32'h0031_8233, controlmux_norm);
        load_regfile_i = 1'b1;
        rd_wr_i        = 5'd3;
        wr_data_i      = 32'hDEAD_BEEF;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("x3_same_cycle", rs1_data_o, 32'hDEAD_BEEF);
`else
        check("x3_same_cycle", rs1_data_o, 32'h0);
`endif
        tick();
        load_regfile_i = 1'b0;
        #1;
        check("x3_rs1_next", rs1_data_o, 32'hDEAD_BEEF);
        check("x3_rs2_next", rs2_data_o, 32'hDEAD_BEEF);
        check("add_rd", rd_o, 32'd4);
        check("add_rs1", rs1_o, 32'd3);
        check("add_aluop", ctrl_word_o.aluop, alu_add);
        check("add_load_rf", ctrl_word_o.load_regfile, 32'd1);

        wr(5'd6, 32'hFFFF_FFFF);
        wr(5'd7, 32'h0000_0001);
        wr(5'd8, 32'h0000_0007);
        wr(5'd9, 32'h0000_0007);
        wr(5'd1, 32'hFFFF_FFFE);
        wr(5'd2, 32'h0000_0055);

        exec(32'h0073_4063, controlmux_norm);
        check("blt_br_en", br_en_o, 32'd1);
        check("blt_cmpop", ctrl_word_o.cmpop, blt);
        check("blt_cmpmux", ctrl_word_o.cmpmux_sel, cmpmux_rs2);
        exec(32'h0073_6063, controlmux_norm);
        check("bltu_br_en", br_en_o, 32'd0);
        exec(32'h0094_0063, controlmux_norm);
        check("beq_br_en", br_en_o, 32'd1);
        exec(32'h0094_1063, controlmux_norm);
        check("bne_br_en", br_en_o, 32'd0);

        exec(32'hFFF0_A293, controlmux_norm);
        check("slti_cmpmux", ctrl_word_o.cmpmux_sel, cmpmux_i_imm);
        check("slti_br_en", br_en_o, 32'd1);
        check("slti_i_imm", i_imm_o, 32'hFFFF_FFFF);
        check("slti_cmpop", ctrl_word_o.cmpop, blt);
        check("slti_rfmux", ctrl_word_o.regfilemux_sel, rfmux_br_en);
        check("slti_load_rf", ctrl_word_o.load_regfile, 32'd1);
        exec(32'hFFF0_A293, controlmux_zero);
        check("slti_sq_load_rf", ctrl_word_o.load_regfile, 32'd0);
        check("slti_sq_cmpop", ctrl_word_o.cmpop, blt);
        check("slti_sq_cmpmux", ctrl_word_o.cmpmux_sel, cmpmux_i_imm);

        exec(32'h0020_A023, controlmux_norm);
        check("sw_mem_write", ctrl_word_o.mem_write, 32'd1);
        check("sw_byte_en", ctrl_word_o.mem_byte_en, 32'hF);
        check("sw_load_rf", ctrl_word_o.load_regfile, 32'd0);
        exec(32'h0020_A023, controlmux_zero);
        check("sw_sq_mem_write", ctrl_word_o.mem_write, 32'd0);
        check("sw_sq_byte_en", ctrl_word_o.mem_byte_en, 32'h0);
        check("sw_sq_load_rf", ctrl_word_o.load_regfile, 32'd0);
        check("sw_sq_aluop", ctrl_word_o.aluop, alu_add);
        check("sw_sq_opcode", ctrl_word_o.opcode, op_store);
        exec(32'h0020_8023, controlmux_norm);
        check("sb_byte_en", ctrl_word_o.mem_byte_en, 32'h1);
        exec(32'h0020_9023, controlmux_norm);
        check("sh_byte_en", ctrl_word_o.mem_byte_en, 32'h3);

        exec(32'h1234_52B7, controlmux_norm);
        check("lui_u_imm", u_imm_o, 32'h1234_5000);
        check("lui_load_rf", ctrl_word_o.load_regfile, 32'd1);
        check("lui_rfmux", ctrl_word_o.regfilemux_sel, rfmux_u_imm);
        exec(32'h0000_007F, controlmux_norm);
        check("unknown_nop", ctrl_word_o, 32'h0);
        exec(32'h0000_0073, controlmux_norm);
        check("csr_nop", ctrl_word_o, 32'h0);

        pc_i = 32'h0000_2468;
        exec(32'hFE00_08E3, controlmux_norm);
        check("imm_b", b_imm_o, 32'hFFFF_FFF0);
        check("imm_i", i_imm_o, 32'hFFFF_FFE0);
        check("imm_s", s_imm_o, 32'hFFFF_FFF1);
        check("imm_u", u_imm_o, 32'hFE00_0000);
        check("imm_j", j_imm_o, 32'hFFF0_07E0);
        check("imm_rs1", rs1_o, 32'd0);
        check("imm_rs2", rs2_o, 32'd0);
        check("imm_br_en", br_en_o, 32'd1);
        check("imm_pc_o", pc_o, 32'h0000_2468);
        check("imm_instr_o", instr_o, 32'hFE00_08E3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
